// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: parity encodings,
// transmitter state encoding and a frame-length helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    // Number of bit periods in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read. Pushes to a full FIFO
// and pops from an empty FIFO are ignored. count carries one extra bit so
// full and empty are distinguishable without pointer wrap tricks.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     push,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // Small storage read combinationally so the consumer can take the head
    // word on the same edge it pops it.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    // Acceptance is decided from the pre-edge count, so a push to a full FIFO
    // is dropped even when a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy tracking; reset flushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a transmit FIFO. Frames are start bit,
// LSB-first data, optional parity and one or two stop bits, each bit lasting
// CLKS_PER_BIT clocks. Queued words go out back-to-back with no idle gap.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          wen,
    output logic                          ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    // The bit counter only ever spans the data or stop field, both shorter than a frame.
    localparam int CNT_W      = $clog2(FRAME_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);

    tx_state_t              state_reg;
    tx_state_t              state_next;
    logic [BAUD_W-1:0]      baud_cnt_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   parity_reg;
    logic                   tx_reg;

    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   bit_done;
    logic                   last_data;
    logic                   last_stop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .push  (wen),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ready     = !fifo_full;
    assign tx_out    = tx_reg;
    assign bit_done  = (baud_cnt_reg == BAUD_LAST);
    assign last_data = (bit_cnt_reg == DATA_LAST);
    assign last_stop = (bit_cnt_reg == STOP_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: advance on bit-period boundaries; chain straight into
    // the next frame when the FIFO still holds data at the end of the stop field.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!fifo_empty) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && last_data) state_next = (PARITY != PARITY_NONE) ? PAR : STOP;
            PAR:     if (bit_done) state_next = STOP;
            STOP:    if (bit_done && last_stop) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: pop the head word whenever a new frame begins.
    always_comb begin
        fifo_pop = 1'b0;
        busy     = (state_reg != IDLE) || !fifo_empty;
        if (!fifo_empty) begin
            if (state_reg == IDLE) begin
                fifo_pop = 1'b1;
            end else if (state_reg == STOP && bit_done && last_stop) begin
                fifo_pop = 1'b1;
            end
        end
    end

    // Datapath: baud counter, bit counter, shift register and registered line.
    // Each register transition sets tx_reg to the level of the bit that starts
    // on that edge, so the line never depends combinationally on inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
        end else if (fifo_pop) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= fifo_dout;
            parity_reg   <= (PARITY == PARITY_ODD) ? ~^fifo_dout : ^fifo_dout;
            tx_reg       <= 1'b0;
        end else if (state_reg == IDLE) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= 1'b1;
        end else if (!bit_done) begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
        end else begin
            baud_cnt_reg <= '0;
            case (state_reg)
                START: tx_reg <= shift_reg[0];
                DATA: begin
                    if (last_data) begin
                        bit_cnt_reg <= '0;
                        tx_reg      <= (PARITY != PARITY_NONE) ? parity_reg : 1'b1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        shift_reg   <= shift_reg >> 1;
                        tx_reg      <= shift_reg[1];
                    end
                end
                PAR: begin
                    bit_cnt_reg <= '0;
                    tx_reg      <= 1'b1;
                end
                STOP: begin
                    bit_cnt_reg <= last_stop ? '0 : bit_cnt_reg + 1'b1;
                    tx_reg      <= 1'b1;
                end
                default: tx_reg <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. Five instances cover 8N1, 8E1, 8O1, 7O2
// and 9N1 framing, all at 4 clocks per bit with a 4-entry FIFO.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [8:0] din_v [5];
    logic [4:0] wen_v;
    logic [4:0] ready_v;
    logic [4:0] tx_v;
    logic [4:0] busy_v;
    logic [2:0] cnt_v [5];

    int tests_run;
    int tests_failed;

    logic [7:0] fd [6];
    int         exp_cnt [6];
    logic       rec [200];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .din(din_v[0][7:0]), .wen(wen_v[0]), .ready(ready_v[0]),
        .tx_out(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .din(din_v[1][7:0]), .wen(wen_v[1]), .ready(ready_v[1]),
        .tx_out(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .din(din_v[2][7:0]), .wen(wen_v[2]), .ready(ready_v[2]),
        .tx_out(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
        .clk(clk), .rst(rst), .din(din_v[3][6:0]), .wen(wen_v[3]), .ready(ready_v[3]),
        .tx_out(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_9n1 (
        .clk(clk), .rst(rst), .din(din_v[4]), .wen(wen_v[4]), .ready(ready_v[4]),
        .tx_out(tx_v[4]), .busy(busy_v[4]), .fifo_count(cnt_v[4]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Queue one word on an idle instance and check the whole frame cycle by
    // cycle. exp_frame bit i is the line level of bit period i.
    task automatic send_and_check(input int idx, input logic [8:0] data,
                                  input logic [11:0] exp_frame, input int nbits);
        logic [3:0] samples;
        logic       ready_all;
        ready_all = 1'b1;
        @(negedge clk);
        din_v[idx] = data;
        wen_v[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wen_v[idx] = 1'b0;
        check_eq($sformatf("u%0d_latency_idle", idx), 32'(tx_v[idx]), 32'd1);
        check_eq($sformatf("u%0d_busy_on_push", idx), 32'(busy_v[idx]), 32'd1);
        for (int b = 0; b < nbits; b++) begin
            samples = '0;
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk);
                @(negedge clk);
                samples[c] = tx_v[idx];
                ready_all  = ready_all & ready_v[idx];
            end
            check_eq($sformatf("u%0d_bit%0d", idx, b), 32'(samples), 32'({4{exp_frame[b]}}));
        end
        check_eq($sformatf("u%0d_busy_last_stop", idx), 32'(busy_v[idx]), 32'd1);
        check_eq($sformatf("u%0d_ready_held", idx), 32'(ready_all), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_eq($sformatf("u%0d_busy_after", idx), 32'(busy_v[idx]), 32'd0);
        check_eq($sformatf("u%0d_tx_idle_after", idx), 32'(tx_v[idx]), 32'd1);
        $display("[TB] u%0d sent 0x%0h, %0d bits", idx, data, nbits);
    endtask

    initial begin
        logic [9:0] frm;
        logic [3:0] samples;
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        wen_v = '0;
        for (int i = 0; i < 5; i++) din_v[i] = '0;
        fd      = '{8'h31, 8'hA7, 8'h0F, 8'hF0, 8'hC3, 8'h99};
        exp_cnt = '{1, 1, 2, 3, 4, 4};

        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(tx_v[0]), 32'd1);
        check_eq("rst_ready", 32'(ready_v[0]), 32'd1);
        check_eq("rst_busy", 32'(busy_v[0]), 32'd0);
        check_eq("rst_count", 32'(cnt_v[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single frames in every framing mode.
        send_and_check(0, 9'h055, {2'b00, 1'b1, 8'h55, 1'b0}, 10);
        send_and_check(1, 9'h055, {1'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
        send_and_check(2, 9'h055, {1'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 11);
        send_and_check(3, 9'h007, {1'b0, 1'b1, 1'b1, 1'b0, 7'h07, 1'b0}, 11);
        send_and_check(4, 9'h1FF, {1'b0, 1'b1, 9'h1FF, 1'b0}, 11);

        // Six back-to-back writes into an idle 4-deep FIFO, then a write to the
        // full FIFO on the edge that pops for the second frame.
        @(negedge clk);
        din_v[0] = {1'b0, fd[0]};
        wen_v[0] = 1'b1;
        for (int k = 0; k <= 201; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k >= 1 && k <= 200) rec[k-1] = tx_v[0];
            if (k <= 5) begin
                check_eq($sformatf("fill_count_w%0d", k + 1), 32'(cnt_v[0]), 32'(exp_cnt[k]));
                check_eq($sformatf("fill_ready_w%0d", k + 1), 32'(ready_v[0]), (k >= 4) ? 32'd0 : 32'd1);
                if (k < 5) din_v[0] = {1'b0, fd[k+1]};
                else wen_v[0] = 1'b0;
            end
            if (k == 40) begin
                check_eq("full_count_before_pop", 32'(cnt_v[0]), 32'd4);
                check_eq("full_ready_before_pop", 32'(ready_v[0]), 32'd0);
                din_v[0] = 9'h000;
                wen_v[0] = 1'b1;
            end
            if (k == 41) begin
                wen_v[0] = 1'b0;
                check_eq("pop_drops_write_count", 32'(cnt_v[0]), 32'd3);
                check_eq("pop_ready_back", 32'(ready_v[0]), 32'd1);
            end
            if (k == 201) begin
                check_eq("burst_end_busy", 32'(busy_v[0]), 32'd0);
                check_eq("burst_end_tx", 32'(tx_v[0]), 32'd1);
                check_eq("burst_end_count", 32'(cnt_v[0]), 32'd0);
            end
        end
        for (int f = 0; f < 5; f++) begin
            frm = {1'b1, fd[f], 1'b0};
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < CPB; c++) samples[c] = rec[f*40 + b*CPB + c];
                check_eq($sformatf("burst_f%0d_bit%0d", f, b), 32'(samples), 32'({4{frm[b]}}));
            end
            $display("[TB] burst frame %0d data 0x%0h checked", f, fd[f]);
        end

        // Reset in the middle of data bit 3 of 0xA5 with two words queued.
        @(negedge clk);
        din_v[0] = 9'h0A5;
        wen_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din_v[0] = 9'h011;
        @(posedge clk);
        @(negedge clk);
        din_v[0] = 9'h022;
        @(posedge clk);
        @(negedge clk);
        wen_v[0] = 1'b0;
        check_eq("mid_queue_count", 32'(cnt_v[0]), 32'd2);
        repeat (16) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("mid_bit3_level", 32'(tx_v[0]), 32'd0);
        #1 rst = 1'b1;
        #1;
        check_eq("async_rst_tx", 32'(tx_v[0]), 32'd1);
        check_eq("async_rst_count", 32'(cnt_v[0]), 32'd0);
        check_eq("async_rst_busy", 32'(busy_v[0]), 32'd0);
        check_eq("async_rst_ready", 32'(ready_v[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset mid-frame applied");
        send_and_check(0, 9'h03C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
